// File: rtl/washmach_pkg.sv
// Shared washing-machine types and constants for the fill/wash and drain/spin phases.
// Combinational definitions only; no latency and no flow control.
package washmach_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATER_IN = 2'd1,
    WASHING  = 2'd2,
    WASH_END = 2'd3
  } fill_wash_state_t;

  localparam int MAX_LEVEL      = 7;
  localparam int WASH_SCALE_DEF = 2;

  typedef logic [$clog2(MAX_LEVEL+1)-1:0] level_t;

  // Wash duration in time units for a given fill level.
  function automatic logic [7:0] wash_units(input level_t level, input int scale);
    return 8'(int'(level) * scale);
  endfunction

endpackage

// File: rtl/wash_timer.sv
// Loadable down-counter stepped by a tick enable, with freeze, sync clear and zero flag.
// Count updates one edge after load/dec; freeze holds the count and overrides load and dec.
module wash_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         freeze,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!freeze) begin
      if (load) begin
        count <= load_val;
      end else if (dec && count != '0) begin
        count <= count - W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fill_wash_mode.sv
// Wash phase: fill drum to a weight-set level, run a timed wash, then hold the end sign.
// Outputs are registered (wash_count lags state by one cycle); start low freezes, en low aborts.
module fill_wash_mode
  import washmach_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int WASH_SCALE = WASH_SCALE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  input  logic             start,
  input  logic             wash_start,
  input  logic [2:0]       weight,
  input  logic             tick,
  input  logic             blink,
  output logic [2:0]       water_level,
  output logic [WIDTH-1:0] wash_count,
  output logic             wash_end_sign,
  output logic             water_in_light,
  output logic             washing_light
);

  fill_wash_state_t state, state_n;
  level_t           target, target_n, level_n;
  logic [WIDTH-1:0] count_n;
  logic             end_n, wil_n, wl_n;
  logic             t_load, t_dec;
  logic [7:0]       remain, units, fill_left;
  logic             remain_zero;

  wire en  = power & wash_start;
  wire run = en & start;

  assign units     = wash_units(target, WASH_SCALE);
  assign fill_left = {5'b0, target - water_level};

  wash_timer #(.W(8)) u_remain (
    .clk      (clk),
    .rst      (rst),
    .clr      (~en),
    .freeze   (~start),
    .load     (t_load),
    .load_val (units),
    .dec      (t_dec),
    .count    (remain),
    .zero     (remain_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      target         <= '0;
      water_level    <= '0;
      wash_count     <= '0;
      wash_end_sign  <= 1'b0;
      water_in_light <= 1'b0;
      washing_light  <= 1'b1;
    end else begin
      state          <= state_n;
      target         <= target_n;
      water_level    <= level_n;
      wash_count     <= count_n;
      wash_end_sign  <= end_n;
      water_in_light <= wil_n;
      washing_light  <= wl_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    level_n  = water_level;
    count_n  = wash_count;
    end_n    = wash_end_sign;
    wil_n    = water_in_light;
    wl_n     = washing_light;
    t_load   = 1'b0;
    t_dec    = 1'b0;

    if (!en) begin
      state_n = IDLE;
      level_n = '0;
      count_n = '0;
      end_n   = 1'b0;
      wil_n   = 1'b0;
      wl_n    = 1'b1;
    end else begin
      // Lights follow blink even while paused.
      if (blink) begin
        case (state)
          IDLE:     begin wil_n = 1'b0;            wl_n = 1'b1;           end
          WATER_IN: begin wil_n = ~water_in_light; wl_n = 1'b1;           end
          WASHING:  begin wil_n = 1'b0;            wl_n = ~washing_light; end
          default:  begin wil_n = 1'b0;            wl_n = 1'b0;           end
        endcase
      end

      if (run) begin
        case (state)
          WATER_IN: count_n = WIDTH'(fill_left + units);
          WASHING:  count_n = WIDTH'(remain);
          default:  count_n = '0;
        endcase

        case (state)
          IDLE: begin
            target_n = (weight == 3'd0) ? 3'd1 : weight;
            state_n  = WATER_IN;
          end
          WATER_IN: if (tick) begin
            level_n = water_level + 3'd1;
            if (level_n == target) begin
              state_n = WASHING;
              t_load  = 1'b1;
            end
          end
          WASHING: begin
            // A zero-length wash (WASH_SCALE 0) ends without waiting for a tick.
            if (remain_zero) begin
              state_n = WASH_END;
              end_n   = 1'b1;
            end else if (tick) begin
              t_dec = 1'b1;
              if (remain == 8'd1) begin
                state_n = WASH_END;
                end_n   = 1'b1;
              end
            end
          end
          default: end_n = 1'b1;
        endcase
      end
    end
  end

endmodule
